// File: rtl/o_reg_serializer.sv
// Queues every change of the core's o_reg and shifts it out as a
// UART-style frame: start bit, 4 data bits LSB first, stop bit.
module o_reg_serializer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic [3:0] o_reg,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       overflow
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    state_t     state, state_nxt;
    logic [3:0] last;
    logic [3:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [3:0] shift, shift_nxt;
    logic [7:0] bit_cnt, cnt_nxt;
    logic [1:0] idx, idx_nxt;
    logic       push_req, push_ok, pop;

    assign fifo_full  = (fifo_count == 3'd4);
    assign fifo_empty = (fifo_count == 3'd0);
    assign busy       = (state != IDLE);

    // Pop sees only the registered count, so a same-edge push is never bypassed
    assign push_req = (o_reg != last);
    assign pop      = (state == IDLE) && !fifo_empty;
    assign push_ok  = push_req && (!fifo_full || pop);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        tx        = 1'b1;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = START;
                    cnt_nxt   = 8'd0;
                    idx_nxt   = 2'd0;
                    shift_nxt = mem[rd_ptr];
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_cnt == LAST_CNT) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = bit_cnt + 8'd1;
                end
            end
            DATA: begin
                tx = shift[0];
                if (bit_cnt == LAST_CNT) begin
                    cnt_nxt   = 8'd0;
                    shift_nxt = shift >> 1;
                    idx_nxt   = idx + 2'd1;
                    if (idx == 2'd3) state_nxt = STOP;
                end else begin
                    cnt_nxt = bit_cnt + 8'd1;
                end
            end
            STOP: begin
                tx = 1'b1;
                if (bit_cnt == LAST_CNT) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = bit_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= IDLE;
            last       <= o_reg;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            overflow   <= 1'b0;
            bit_cnt    <= 8'd0;
            idx        <= 2'd0;
            shift      <= 4'd0;
        end else begin
            state   <= state_nxt;
            last    <= o_reg;
            bit_cnt <= cnt_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            if (push_ok) begin
                mem[wr_ptr] <= o_reg;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            if (push_req && !push_ok) overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_o_reg_serializer.sv
// Bench for o_reg_serializer: random and directed stimulus against a
// frame-position reference model, plus a CLKS_PER_BIT=1 instance.
module tb_o_reg_serializer;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       sr0, sr1;
    logic [3:0] o0, o1;
    logic       tx0, busy0, full0, empty0, ovf0;
    logic       tx1, busy1, full1, empty1, ovf1;
    logic [2:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    o_reg_serializer #(.CLKS_PER_BIT(C)) u0 (
        .clk(clk), .sync_reset(sr0), .o_reg(o0), .tx(tx0), .busy(busy0),
        .fifo_count(cnt0), .fifo_full(full0), .fifo_empty(empty0),
        .overflow(ovf0)
    );

    o_reg_serializer #(.CLKS_PER_BIT(1)) u1 (
        .clk(clk), .sync_reset(sr1), .o_reg(o1), .tx(tx1), .busy(busy1),
        .fifo_count(cnt1), .fifo_full(full1), .fifo_empty(empty1),
        .overflow(ovf1)
    );

    // Reference model: a queue of pending nibbles and the position inside
    // the frame currently on the wire.
    logic [3:0] m_q[$];
    logic [3:0] m_last;
    logic [3:0] m_cur;
    bit         m_active;
    int         m_pos;
    bit         m_ovf;

    function automatic logic [7:0] mvec();
        logic t;
        int   n;
        n = m_q.size();
        t = 1'b1;
        if (m_active) begin
            if (m_pos < C) t = 1'b0;
            else if (m_pos < 5 * C) t = m_cur[(m_pos - C) / C];
        end
        return {t, m_active, 3'(n), n == 4, n == 0, m_ovf};
    endfunction

    function automatic logic [7:0] dvec();
        return {tx0, busy0, cnt0, full0, empty0, ovf0};
    endfunction

    task automatic model_edge();
        bit do_pop;
        do_pop = !m_active && (m_q.size() != 0);
        if (m_active) begin
            m_pos++;
            if (m_pos == 6 * C) m_active = 0;
        end
        if (do_pop) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_pos    = 0;
        end
        if (o0 != m_last) begin
            if (m_q.size() < 4) m_q.push_back(o0);
            else m_ovf = 1;
        end
        m_last = o0;
    endtask

    task automatic tick(input logic [3:0] v);
        o0 = v;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input logic [3:0] v);
        sr0 = 1'b1;
        o0  = v;
        @(posedge clk);
        m_q.delete();
        m_active = 0;
        m_pos    = 0;
        m_ovf    = 0;
        m_last   = v;
        #1;
        sr0 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4'h3);
        checks++;
        if (dvec() !== 8'b1_0_000_0_1_0) begin
            errors++;
            $display("FAIL reset_state got=%b exp=%b", dvec(), 8'b10000010);
        end
        for (int i = 0; i < 30; i++) begin
            tick(4'h3);
            checks++;
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || dvec() !== mvec()) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b",
                         i, dvec(), mvec());
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] v;
        logic       et;
        int         p;
        v = 4'hA;
        tick(v);
        checks++;
        if (dvec() !== mvec() || cnt0 !== 3'd1 || tx0 !== 1'b1) begin
            errors++;
            $display("FAIL single_push got=%b exp=%b", dvec(), mvec());
        end
        for (int k = 1; k <= 25; k++) begin
            tick(v);
            p  = k - 1;
            et = 1'b1;
            if (p < 4) et = 1'b0;
            else if (p < 20) et = v[(p - 4) / 4];
            checks++;
            if (tx0 !== et || busy0 !== (k <= 24) || dvec() !== mvec()) begin
                errors++;
                $display("FAIL single_frame k=%0d tx=%b/%b busy=%b vec=%b/%b",
                         k, tx0, et, busy0, dvec(), mvec());
            end
        end
    endtask

    task automatic test_burst();
        logic   tx_s [200];
        logic   bz_s [200];
        logic [3:0] got[$];
        logic [3:0] nib;
        int     n;
        n = 0;
        for (int v = 1; v <= 6; v++) begin
            tick(4'(v));
            tx_s[n] = tx0;
            bz_s[n] = busy0;
            n++;
            if (v == 5) begin
                checks++;
                if (cnt0 !== 3'd4 || full0 !== 1'b1 || ovf0 !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_full cnt=%0d full=%b ovf=%b exp 4 1 0",
                             cnt0, full0, ovf0);
                end
            end
            if (v == 6) begin
                checks++;
                if (cnt0 !== 3'd4 || ovf0 !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_overflow cnt=%0d ovf=%b exp 4 1",
                             cnt0, ovf0);
                end
            end
        end
        for (int i = 0; i < 140; i++) begin
            tick(4'h6);
            tx_s[n] = tx0;
            bz_s[n] = busy0;
            n++;
            checks++;
            if (dvec() !== mvec()) begin
                errors++;
                $display("FAIL burst_model cyc=%0d got=%b exp=%b",
                         i, dvec(), mvec());
            end
        end
        for (int i = 0; i + 6 * C <= n; i++) begin
            if (bz_s[i] === 1'b1 && (i == 0 || bz_s[i-1] === 1'b0)) begin
                for (int b = 0; b < 4; b++) nib[b] = tx_s[i + C * (1 + b)];
                got.push_back(nib);
            end
        end
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL burst_frames count got=%0d exp=5", got.size());
        end else begin
            for (int f = 0; f < 5; f++) begin
                checks++;
                if (got[f] !== 4'(f + 1)) begin
                    errors++;
                    $display("FAIL burst_order frame=%0d got=%h exp=%h",
                             f, got[f], f + 1);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        bit hit;
        do_reset(4'h0);
        for (int v = 1; v <= 5; v++) tick(4'(v));
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick(4'h5);
            if (!m_active && m_q.size() == 4) hit = 1;
        end
        checks++;
        if (!hit || cnt0 !== 3'd4 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL full_idle_wait hit=%0d cnt=%0d busy=%b exp 1 4 0",
                     hit, cnt0, busy0);
        end
        tick(4'h6);
        checks++;
        if (cnt0 !== 3'd4 || ovf0 !== 1'b0 || busy0 !== 1'b1 ||
            dvec() !== mvec()) begin
            errors++;
            $display("FAIL full_push_pop cnt=%0d ovf=%b busy=%b exp 4 0 1",
                     cnt0, ovf0, busy0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(4'h0);
        tick(4'h1);
        tick(4'h2);
        tick(4'h3);
        for (int i = 0; i < C + 3; i++) tick(4'h3);
        checks++;
        if (cnt0 !== 3'd2 || busy0 !== 1'b1 || m_pos < C || m_pos >= 5 * C) begin
            errors++;
            $display("FAIL mid_setup cnt=%0d busy=%b pos=%0d exp 2 1 data",
                     cnt0, busy0, m_pos);
        end
        do_reset(4'h3);
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0 || empty0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", dvec(), 8'b10000010);
        end
        for (int i = 0; i < 40; i++) begin
            tick(4'h3);
            checks++;
            if (busy0 !== 1'b0 || tx0 !== 1'b1) begin
                errors++;
                $display("FAIL mid_no_frame cyc=%0d busy=%b tx=%b exp 0 1",
                         i, busy0, tx0);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v;
        for (int r = 0; r < 3; r++) begin
            v = 4'($urandom_range(0, 15));
            do_reset(v);
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 2 + 6 * r) == 0) v = 4'($urandom_range(0, 15));
                tick(v);
                checks++;
                if (dvec() !== mvec()) begin
                    errors++;
                    $display("FAIL random r=%0d cyc=%0d got=%b exp=%b",
                             r, i, dvec(), mvec());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] txe;
        logic [13:0] bse;
        txe = 14'b1010101_1010011;
        bse = 14'b0111111_0111111;
        sr1 = 1'b1;
        o1  = 4'h0;
        @(posedge clk);
        #1;
        sr1 = 1'b0;
        o1  = 4'h5;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            o1 = 4'h9;
            checks++;
            if (tx1 !== txe[13-k] || busy1 !== bse[13-k]) begin
                errors++;
                $display("FAIL b2b k=%0d tx=%b/%b busy=%b/%b",
                         k, tx1, txe[13-k], busy1, bse[13-k]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || empty1 !== 1'b1 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end tx=%b busy=%b empty=%b ovf=%b exp 1 0 1 0",
                     tx1, busy1, empty1, ovf1);
        end
    endtask

    initial begin
        sr0 = 1'b1;
        sr1 = 1'b1;
        o0  = 4'h3;
        o1  = 4'h0;
        m_last = 4'h3;
        m_active = 0;
        m_pos = 0;
        m_ovf = 0;
        m_cur = 4'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_burst();
        test_full_pop();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/o_reg_serializer.md
# o_reg_serializer

Output-port serializer sitting directly downstream of the 4-bit microprocessor's `o_reg` output. Every change of `o_reg` is queued as a nibble in a 4-entry FIFO. The nibble is then shifted out on a single-wire, UART-style line: start bit, 4 data bits LSB first, stop bit. This gives the core an observable serial trace without stalling it.

## Interface
- `CLKS_PER_BIT`, default 4: clk cycles per serial bit; legal range 1..255.
- `clk`  input  1  system clock, same clock as the processor core.
- `sync_reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `o_reg`  input  4  processor output register value, registered in the core on `clk`.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  high while a frame is in progress (state != IDLE).
- `fifo_count`  output  3  queued nibbles not yet started, 0..4.
- `fifo_full`  output  1  `fifo_count == 4`.
- `fifo_empty`  output  1  `fifo_count == 0`.
- `overflow`  output  1  sticky flag; set when a change is dropped because the FIFO is full.

## Operation
- All state updates on the rising `clk` edge. All outputs registered or decoded directly from registers.
- Reset values (`sync_reset` high at an edge):
  - `tx=1`, `busy=0`, `fifo_count=0`, `fifo_empty=1`, `fifo_full=0`, `overflow=0`.
  - FSM goes to IDLE; read/write pointers go to 0.
  - `last` register loads the current `o_reg`; no push occurs.
- Change detect:
  - Every non-reset edge, compare `o_reg` with `last`, then load `last <= o_reg`.
  - A mismatch is a push request carrying the current `o_reg`.
  - Writing the same value again generates no push.
- FIFO: depth 4, 4-bit entries, 2-bit read/write pointers wrapping 3->0.
  - Push request when not full: write the entry, increment `fifo_count`.
  - Push request when full and no pop that edge: drop the entry, set `overflow=1`. `overflow` clears only on reset.
  - Simultaneous push and pop: both happen, `fifo_count` unchanged. This includes the full case (push accepted, no overflow) and `count==1`.
  - No bypass: a nibble pushed at edge E is not eligible for pop until edge E+1.
- Transmit FSM, with a bit counter (0..CLKS_PER_BIT-1) and a data-bit index (0..3):
  - IDLE: `tx=1`. If `fifo_count != 0`, pop the head into the shift register, clear the counters, go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx = shift[0]` for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 3, go to STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles, then IDLE.
  - Frame length is exactly 6*CLKS_PER_BIT cycles. At least one IDLE cycle (`tx=1`) separates consecutive frames.
- Reset mid-frame aborts the frame. `tx` returns to 1 and queued entries are discarded.

## Timing
- Push/launch latency: `o_reg` changes between edges E-1 and E. The nibble is pushed at edge E and popped at E+1. `tx` falls after edge E+1, and `busy` rises at the same edge.
- Each bit lasts exactly CLKS_PER_BIT cycles. The stop bit ends at edge E+1+6*CLKS_PER_BIT, where the FSM enters IDLE.
- With an empty FIFO, the next launch is no earlier than 1 cycle after entering IDLE.
- Sustained rate: one frame per 6*CLKS_PER_BIT+1 cycles. Changes arriving faster than this beyond 4 queued entries set `overflow`.
- `fifo_count`, `fifo_full` and `fifo_empty` reflect pushes and pops of the same edge. They are valid one cycle after that edge.

## Test plan
- Reset with `o_reg=4'h3` held: `tx=1`, `busy=0`, `fifo_empty=1`, `overflow=0`. No frame is ever sent while `o_reg` stays 3.
- Single change 3->A at edge E, CLKS_PER_BIT=4:
  - `tx` holds 0 for 4 cycles (start), then data 0,1,0,1 for 4 cycles each, then 1 for 4 cycles (stop).
  - `tx` falls after E+1; `busy` falls at E+25.
- Burst of values 1,2,3,4,5,6 on six consecutive edges from idle:
  - Count reaches 4 after the value-5 push; value 6 is dropped and `overflow=1`.
  - Frames carry 1,2,3,4,5 in order.
- Push while full, coinciding with a pop at IDLE: the entry is accepted, `fifo_count` stays 4, `overflow` stays 0.
- Reset asserted mid-DATA with 2 entries queued: after that edge `tx=1`, `busy=0`, `fifo_count=0`, and no further frames are sent.
- CLKS_PER_BIT=1 back-to-back: changes 5 then 9 on consecutive edges produce frames 0,1,0,1,0,1 and 0,1,0,0,1,1. Exactly one idle-high cycle separates them.
